// File: rtl/controle_exploracao_pkg.sv
// exploracao_pkg: shared types and helpers for the exploration controller.
//   estado_e  : mission FSM states
//   direcao_e : step direction codes sent to the motor driver
//   celula_e  : map cell codes written to the shared map RAM
//   sentinela : all-ones "no target" value for a given coordinate width
package exploracao_pkg;

    typedef enum logic [2:0] {
        OCIOSO,
        SOLICITA,
        AGUARDA,
        AVALIA,
        MOVE,
        ESPERA_PASSO,
        MARCA,
        FIM
    } estado_e;

    typedef enum logic [1:0] {
        DIR_MAIS_X  = 2'b00,
        DIR_MENOS_X = 2'b01,
        DIR_MAIS_Y  = 2'b10,
        DIR_MENOS_Y = 2'b11
    } direcao_e;

    typedef enum logic [1:0] {
        CELULA_LIVRE     = 2'b00,
        CELULA_VISITADA  = 2'b01,
        CELULA_OBSTACULO = 2'b10,
        CELULA_ALVO      = 2'b11
    } celula_e;

    // All-ones value of a coordinate 'largura' bits wide; usable in localparams.
    function automatic int unsigned sentinela(input int unsigned largura);
        return (32'd1 << largura) - 32'd1;
    endfunction

endpackage

// File: rtl/controle_exploracao_if.sv
// controle_exploracao_if: bundle of the search, motor and map signals around
// the exploration controller.
//   master : controller side (drives novoDado, enable, position, step command,
//            map write, status)
//   slave  : environment side (drives iniciar, quadrantes, search result,
//            passoConcluido)
interface controle_exploracao_if #(
    parameter int TamanhoMalha     = 8,
    parameter int tamanhoDistancia = 8
);
    localparam int LARGURA_ENDERECO = $clog2(TamanhoMalha * TamanhoMalha);

    logic                          iniciar;
    logic [3:0]                    quadrantes;
    logic                          operacaoFinalizada;
    logic [tamanhoDistancia-1:0]   destinoX;
    logic [tamanhoDistancia-1:0]   destinoY;
    logic                          passoConcluido;

    logic                          novoDado;
    logic [3:0]                    enable;
    logic [tamanhoDistancia-1:0]   posicaoAtualnoEixoX;
    logic [tamanhoDistancia-1:0]   posicaoAtualnoEixoY;
    logic                          comandoValido;
    logic [1:0]                    comandoDirecao;
    logic                          escritaMalha;
    logic [LARGURA_ENDERECO-1:0]   enderecoMalha;
    logic [1:0]                    valorMalha;
    logic                          ocupado;
    logic                          concluido;
    logic                          erroTimeout;

    modport master (
        input  iniciar, quadrantes, operacaoFinalizada, destinoX, destinoY, passoConcluido,
        output novoDado, enable, posicaoAtualnoEixoX, posicaoAtualnoEixoY, comandoValido,
               comandoDirecao, escritaMalha, enderecoMalha, valorMalha, ocupado, concluido,
               erroTimeout
    );

    modport slave (
        output iniciar, quadrantes, operacaoFinalizada, destinoX, destinoY, passoConcluido,
        input  novoDado, enable, posicaoAtualnoEixoX, posicaoAtualnoEixoY, comandoValido,
               comandoDirecao, escritaMalha, enderecoMalha, valorMalha, ocupado, concluido,
               erroTimeout
    );

endinterface

// File: rtl/controle_exploracao_passo_direcao.sv
// passo_direcao: combinational next-step direction (X corrected before Y)
// and at-destination compare.
//   pos_x_i, pos_y_i   : current position
//   dest_x_i, dest_y_i : destination
//   direcao_o          : direction of the next single-cell step
//   no_destino_o       : position equals destination
module passo_direcao
    import exploracao_pkg::*;
#(
    parameter int LARGURA = 8
) (
    input  logic [LARGURA-1:0] pos_x_i,
    input  logic [LARGURA-1:0] pos_y_i,
    input  logic [LARGURA-1:0] dest_x_i,
    input  logic [LARGURA-1:0] dest_y_i,
    output direcao_e           direcao_o,
    output logic               no_destino_o
);

    always_comb begin
        direcao_o = DIR_MAIS_X;
        if (pos_x_i < dest_x_i)      direcao_o = DIR_MAIS_X;
        else if (pos_x_i > dest_x_i) direcao_o = DIR_MENOS_X;
        else if (pos_y_i < dest_y_i) direcao_o = DIR_MAIS_Y;
        else if (pos_y_i > dest_y_i) direcao_o = DIR_MENOS_Y;
    end

    assign no_destino_o = (pos_x_i == dest_x_i) && (pos_y_i == dest_y_i);

endmodule

// File: rtl/controle_exploracao.sv
// controle_exploracao: mission-level initiator for the nearest-target search.
// Requests a search, steps the robot one cell at a time toward the returned
// destination via the motor handshake, and marks the reached cell visited.
//   clock, reset : rising-edge clock, asynchronous active-high reset
//   bus (master) : search request/result, motor step command, map write, status
// Optional feature: define CONTROLE_EXPLORACAO_TIMEOUT_EN to bound the waits in
// AGUARDA and ESPERA_PASSO by TIMEOUT_CICLOS cycles (sticky erroTimeout).
module controle_exploracao
    import exploracao_pkg::*;
#(
    parameter int TamanhoMalha     = 8,
    parameter int tamanhoDistancia = 8,
    parameter int TIMEOUT_CICLOS   = 4096
) (
    input  logic                  clock,
    input  logic                  reset,
    controle_exploracao_if.master bus
);

    localparam int             W         = tamanhoDistancia;
    localparam int             LE        = $clog2(TamanhoMalha * TamanhoMalha);
    localparam logic [W-1:0]   SENTINELA = W'(sentinela(W));
    localparam logic [W-1:0]   LIMITE    = W'(TamanhoMalha);
    localparam logic [W-1:0]   UM        = W'(1);

    if (TIMEOUT_CICLOS < 1) begin : g_timeout_invalido
        $error("TIMEOUT_CICLOS must be at least 1");
    end

    estado_e      estado_q, estado_d;
    logic [W-1:0] pos_x_q, pos_x_d, pos_y_q, pos_y_d;
    logic [W-1:0] dest_x_q, dest_y_q;
    logic [3:0]   enable_q;
    logic         op_q;
    logic         valido_q, valido_d;
    direcao_e     dir_q, dir_d, dir_calc;
    logic         no_destino, destino_invalido, borda_op, inicio_aceito, tempo_esgotado;

    // Only a fresh rising edge counts: a level still high from the previous
    // search is stale.
    assign borda_op      = bus.operacaoFinalizada && !op_q;
    assign inicio_aceito = bus.iniciar && (estado_q == OCIOSO || estado_q == FIM);
    // Any off-grid coordinate is handled like the "no target" sentinel.
    assign destino_invalido = (dest_x_q == SENTINELA && dest_y_q == SENTINELA) ||
                              (dest_x_q >= LIMITE) || (dest_y_q >= LIMITE);

    // Position update kept apart from the FSM so the at-destination compare
    // below sees the post-step position without a combinational loop.
    always_comb begin : posicao
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        pos_x_d = pos_x_q;
        pos_y_d = pos_y_q;
        if (estado_q == ESPERA_PASSO && bus.passoConcluido) begin
            unique case (dir_q)
                DIR_MAIS_X:  pos_x_d = pos_x_q + UM;
                DIR_MENOS_X: pos_x_d = pos_x_q - UM;
                DIR_MAIS_Y:  pos_y_d = pos_y_q + UM;
                DIR_MENOS_Y: pos_y_d = pos_y_q - UM;
            endcase
        end
    end

    passo_direcao #(.LARGURA(W)) u_passo_direcao (
        .pos_x_i      (pos_x_d),
        .pos_y_i      (pos_y_d),
        .dest_x_i     (dest_x_q),
        .dest_y_i     (dest_y_q),
        .direcao_o    (dir_calc),
        .no_destino_o (no_destino)
    );

    always_comb begin : proximo_estado
        estado_d = estado_q;
        valido_d = 1'b0;
        unique case (estado_q)
            OCIOSO:   if (inicio_aceito) estado_d = SOLICITA;
            SOLICITA: estado_d = AGUARDA;
            AGUARDA: begin
                if (borda_op)            estado_d = AVALIA;
                else if (tempo_esgotado) estado_d = FIM;
            end
            AVALIA: begin
                if (destino_invalido) estado_d = FIM;
                else if (no_destino)  estado_d = MARCA;
                else begin
                    // First command of a move is raised already in MOVE.
                    estado_d = MOVE;
                    valido_d = 1'b1;
                end
            end
            MOVE: begin
                estado_d = ESPERA_PASSO;
                valido_d = 1'b1;
            end
            ESPERA_PASSO: begin
                valido_d = 1'b1;
                if (bus.passoConcluido) begin
                    // Dropping here gives exactly one low cycle (MOVE) before the next step.
                    valido_d = 1'b0;
                    estado_d = no_destino ? MARCA : MOVE;
                end else if (tempo_esgotado) begin
                    valido_d = 1'b0;
                    estado_d = FIM;
                end
            end
            MARCA: estado_d = SOLICITA;
            FIM:   if (inicio_aceito) estado_d = SOLICITA;
        endcase
        dir_d = valido_d ? dir_calc : DIR_MAIS_X;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estado_q <= OCIOSO;
            pos_x_q  <= '0;
            pos_y_q  <= '0;
            dest_x_q <= '0;
            dest_y_q <= '0;
            enable_q <= '0;
            op_q     <= 1'b0;
            valido_q <= 1'b0;
            dir_q    <= DIR_MAIS_X;
        end else begin
            // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
            estado_q <= estado_d;
            pos_x_q  <= pos_x_d;
            pos_y_q  <= pos_y_d;
            valido_q <= valido_d;
            dir_q    <= dir_d;
            op_q     <= bus.operacaoFinalizada;
            if (inicio_aceito) enable_q <= bus.quadrantes;
            if (estado_q == AGUARDA && borda_op) begin
                dest_x_q <= bus.destinoX;
                dest_y_q <= bus.destinoY;
            end
        end
    end

`ifdef CONTROLE_EXPLORACAO_TIMEOUT_EN
    localparam int              LC       = $clog2(TIMEOUT_CICLOS + 1);
    localparam logic [LC-1:0]   ULTIMO   = LC'(TIMEOUT_CICLOS - 1);

    logic [LC-1:0] contador_q;
    logic          erro_q;
    logic          em_espera;

    assign em_espera      = (estado_q == AGUARDA) || (estado_q == ESPERA_PASSO);
    assign tempo_esgotado = em_espera && (contador_q == ULTIMO);

    // Counter restarts on every entry to a wait state, so each wait gets the full budget.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            contador_q <= '0;
            erro_q     <= 1'b0;
        end else begin
            if (em_espera && estado_d == estado_q) contador_q <= contador_q + LC'(1);
            else                                   contador_q <= '0;
            if (tempo_esgotado)     erro_q <= 1'b1;
            else if (inicio_aceito) erro_q <= 1'b0;
        end
    end

    assign bus.erroTimeout = erro_q;
`else
    assign tempo_esgotado  = 1'b0;
    assign bus.erroTimeout = 1'b0;
`endif

    assign bus.novoDado            = (estado_q == SOLICITA);
    assign bus.enable              = enable_q;
    assign bus.posicaoAtualnoEixoX = pos_x_q;
    assign bus.posicaoAtualnoEixoY = pos_y_q;
    assign bus.comandoValido       = valido_q;
    assign bus.comandoDirecao      = dir_q;
    assign bus.escritaMalha        = (estado_q == MARCA);
    assign bus.enderecoMalha       = LE'(pos_x_q) + LE'(pos_y_q) * LE'(TamanhoMalha);
    assign bus.valorMalha          = CELULA_VISITADA;
    assign bus.ocupado             = (estado_q != OCIOSO) && (estado_q != FIM);
    assign bus.concluido           = (estado_q == FIM);

endmodule

// File: tb/tb_controle_exploracao.sv
// Self-checking bench for controle_exploracao. A reference model tracks the
// robot position and plans each move as a queue of unit steps (all X steps,
// then all Y steps); the bench plays the roles of distancias and the motor.
module tb_controle_exploracao;

    localparam int TAM     = 8;
    localparam int LARG    = 8;
    localparam int TIMEOUT = 16;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    controle_exploracao_if #(.TamanhoMalha(TAM), .tamanhoDistancia(LARG)) bus ();

    controle_exploracao #(
        .TamanhoMalha     (TAM),
        .tamanhoDistancia (LARG),
        .TIMEOUT_CICLOS   (TIMEOUT)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int vectors     = 0;
    int miscompares = 0;
    int px = 0;
    int py = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // From OCIOSO: accept iniciar, expect the search request next cycle.
    task automatic start_mission();
        int q;
        q = int'($urandom_range(0, 15));
        bus.iniciar    = 1'b1;
        bus.quadrantes = 4'(q);
        step();
        bus.iniciar    = 1'b0;
        bus.quadrantes = 4'($urandom);
        check("inicio_novoDado", 32'(bus.novoDado), 1);
        check("inicio_enable", 32'(bus.enable), q);
        check("inicio_ocupado", 32'(bus.ocupado), 1);
    endtask

    // From FIM: iniciar restarts the search with the position held.
    task automatic restart();
        bus.iniciar = 1'b1;
        step();
        bus.iniciar = 1'b0;
        check("reinicio_novoDado", 32'(bus.novoDado), 1);
        check("reinicio_pos_x", 32'(bus.posicaoAtualnoEixoX), px);
        check("reinicio_pos_y", 32'(bus.posicaoAtualnoEixoY), py);
        check("reinicio_erro", 32'(bus.erroTimeout), 0);
    endtask

    // From SOLICITA: deliver (dx,dy) and walk to the first MOVE cycle.
    task automatic to_move(input int dx, input int dy);
        step();
        bus.operacaoFinalizada = 1'b1;
        bus.destinoX = 8'(dx);
        bus.destinoY = 8'(dy);
        step();
        bus.operacaoFinalizada = 1'b0;
        step();
        check("move_valido", 32'(bus.comandoValido), 1);
    endtask

    // One full search round from the SOLICITA cycle.
    task automatic search(input int dx, input int dy, input bit stale);
        int dq[$];
        int d;
        if (stale) begin
            bus.operacaoFinalizada = 1'b1;
            bus.destinoX = 8'(dx);
            bus.destinoY = 8'(dy);
            repeat (4) begin
                step();
                check("stale_valido", 32'(bus.comandoValido), 0);
                check("stale_escrita", 32'(bus.escritaMalha), 0);
                check("stale_concluido", 32'(bus.concluido), 0);
            end
            bus.operacaoFinalizada = 1'b0;
        end
        step();
        repeat ($urandom_range(0, 3)) begin
            bus.passoConcluido = 1'($urandom_range(0, 1));
            bus.iniciar        = 1'($urandom_range(0, 1));
            step();
        end
        bus.passoConcluido     = 1'b0;
        bus.iniciar            = 1'b0;
        bus.operacaoFinalizada = 1'b1;
        bus.destinoX = 8'(dx);
        bus.destinoY = 8'(dy);
        step();
        bus.operacaoFinalizada = 1'b0;
        bus.destinoX = 8'($urandom);
        bus.destinoY = 8'($urandom);
        check("avalia_valido", 32'(bus.comandoValido), 0);
        check("avalia_pos_x", 32'(bus.posicaoAtualnoEixoX), px);
        check("avalia_pos_y", 32'(bus.posicaoAtualnoEixoY), py);
        step();
        if (dx >= TAM || dy >= TAM) begin
            check("fim_concluido", 32'(bus.concluido), 1);
            check("fim_ocupado", 32'(bus.ocupado), 0);
            check("fim_valido", 32'(bus.comandoValido), 0);
            return;
        end
        for (int i = 0; i < dx - px; i++) dq.push_back(0);
        for (int i = 0; i < px - dx; i++) dq.push_back(1);
        for (int i = 0; i < dy - py; i++) dq.push_back(2);
        for (int i = 0; i < py - dy; i++) dq.push_back(3);
        while (dq.size() > 0) begin
            d = dq.pop_front();
            check("passo_valido", 32'(bus.comandoValido), 1);
            check("passo_direcao", 32'(bus.comandoDirecao), d);
            repeat ($urandom_range(1, 3)) begin
                step();
                check("passo_valido_mantido", 32'(bus.comandoValido), 1);
                check("passo_direcao_mantida", 32'(bus.comandoDirecao), d);
            end
            bus.passoConcluido = 1'b1;
            step();
            bus.passoConcluido = 1'b0;
            case (d)
                0: px++;
                1: px--;
                2: py++;
                default: py--;
            endcase
            check("passo_pos_x", 32'(bus.posicaoAtualnoEixoX), px);
            check("passo_pos_y", 32'(bus.posicaoAtualnoEixoY), py);
            check("passo_valido_baixo", 32'(bus.comandoValido), 0);
            if (dq.size() > 0) step();
        end
        check("marca_escrita", 32'(bus.escritaMalha), 1);
        check("marca_endereco", 32'(bus.enderecoMalha), px + TAM * py);
        check("marca_valor", 32'(bus.valorMalha), 1);
        step();
        check("marca_novoDado", 32'(bus.novoDado), 1);
        check("marca_escrita_baixa", 32'(bus.escritaMalha), 0);
    endtask

    initial begin
        int dx;
        int dy;
        reset                  = 1'b1;
        bus.iniciar            = 1'b0;
        bus.quadrantes         = 4'b0;
        bus.operacaoFinalizada = 1'b0;
        bus.destinoX           = 8'b0;
        bus.destinoY           = 8'b0;
        bus.passoConcluido     = 1'b0;

        repeat (2) step();
        check("reset_novoDado", 32'(bus.novoDado), 0);
        check("reset_enable", 32'(bus.enable), 0);
        check("reset_pos_x", 32'(bus.posicaoAtualnoEixoX), 0);
        check("reset_pos_y", 32'(bus.posicaoAtualnoEixoY), 0);
        check("reset_valido", 32'(bus.comandoValido), 0);
        check("reset_direcao", 32'(bus.comandoDirecao), 0);
        check("reset_escrita", 32'(bus.escritaMalha), 0);
        check("reset_endereco", 32'(bus.enderecoMalha), 0);
        check("reset_ocupado", 32'(bus.ocupado), 0);
        check("reset_concluido", 32'(bus.concluido), 0);
        check("reset_erro", 32'(bus.erroTimeout), 0);
        reset = 1'b0;
        step();
        check("ocioso_ocupado", 32'(bus.ocupado), 0);

        start_mission();
        search(2, 3, 1'b0);
        search(2, 3, 1'b0);
        search(int'($urandom_range(0, 7)), (py + 4) % TAM, 1'b1);
        repeat (12) begin
            if ($urandom_range(0, 3) == 0) begin
                dx = px;
                dy = py;
            end else begin
                dx = int'($urandom_range(0, TAM - 1));
                dy = int'($urandom_range(0, TAM - 1));
            end
            search(dx, dy, 1'b0);
        end

        search(255, 255, 1'b0);
        repeat (3) begin
            bus.passoConcluido = 1'b1;
            step();
            check("fim_mantido", 32'(bus.concluido), 1);
            check("fim_pos_x", 32'(bus.posicaoAtualnoEixoX), px);
        end
        bus.passoConcluido = 1'b0;
        restart();
        search(9, 1, 1'b0);
        restart();

`ifdef CONTROLE_EXPLORACAO_TIMEOUT_EN
        to_move((px + 1) % TAM, py);
        repeat (TIMEOUT) step();
        check("timeout_erro_antes", 32'(bus.erroTimeout), 0);
        check("timeout_valido_antes", 32'(bus.comandoValido), 1);
        step();
        check("timeout_erro", 32'(bus.erroTimeout), 1);
        check("timeout_concluido", 32'(bus.concluido), 1);
        check("timeout_valido", 32'(bus.comandoValido), 0);
        check("timeout_pos_x", 32'(bus.posicaoAtualnoEixoX), px);
`else
        step();
        repeat (40) step();
        check("espera_sem_timeout_erro", 32'(bus.erroTimeout), 0);
        check("espera_sem_timeout_ocupado", 32'(bus.ocupado), 1);
        bus.operacaoFinalizada = 1'b1;
        bus.destinoX = 8'hFF;
        bus.destinoY = 8'hFF;
        step();
        bus.operacaoFinalizada = 1'b0;
        step();
        check("espera_sem_timeout_fim", 32'(bus.concluido), 1);
`endif
        restart();

        to_move((px + 1) % TAM, py);
        step();
        check("espera_valido", 32'(bus.comandoValido), 1);
        #2;
        reset = 1'b1;
        #1;
        px = 0;
        py = 0;
        check("reset_meio_valido", 32'(bus.comandoValido), 0);
        check("reset_meio_pos_x", 32'(bus.posicaoAtualnoEixoX), 0);
        check("reset_meio_pos_y", 32'(bus.posicaoAtualnoEixoY), 0);
        repeat (3) begin
            step();
            check("reset_meio_escrita", 32'(bus.escritaMalha), 0);
            check("reset_meio_ocupado", 32'(bus.ocupado), 0);
        end
        reset = 1'b0;
        step();

        start_mission();
        repeat (3) search(int'($urandom_range(0, TAM - 1)), int'($urandom_range(0, TAM - 1)), 1'b0);
        search(255, 255, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
